// File: rtl/gain_ramp_multi.sv
`default_nettype none
// ============================================================================
// Module   : gain_ramp_multi
// Brief    : Multi-channel gain stage with per-frame gain ramping, rounding,
//            saturation and clip flags. One shared multiplier walks the
//            channels of a latched frame one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module gain_ramp_multi #(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 24,
  parameter int GAIN_W    = 16,
  parameter int FRAC_W    = 12,
  parameter int RAMP_STEP = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         sample_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples_in,
  input  logic [GAIN_W-1:0]            target_gain,
  input  logic                         mute,
  output logic [NUM_CH*SAMPLE_W-1:0]   samples_out,
  output logic                         out_valid,
  output logic [NUM_CH-1:0]            clip,
  output logic [GAIN_W-1:0]            cur_gain,
  output logic                         busy,
  output logic                         overrun
);

  localparam int c_idx_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_prod_w = SAMPLE_W + GAIN_W + 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mul  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CH - 1);
  localparam logic [GAIN_W-1:0]  c_unity    = GAIN_W'(1 << FRAC_W);
  localparam logic [GAIN_W-1:0]  c_step     = GAIN_W'(RAMP_STEP);

  // Rounding constant: half an LSB of the output after the FRAC_W shift.
  localparam logic signed [c_prod_w-1:0] c_round =
    {{(c_prod_w-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [c_prod_w-1:0] c_sat_max =
    {{(c_prod_w-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [c_prod_w-1:0] c_sat_min =
    {{(c_prod_w-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_nxt;
  logic [c_idx_w-1:0]          r_idx;
  logic [GAIN_W-1:0]           r_cur_gain;
  logic                        r_overrun;
  logic signed [SAMPLE_W-1:0]  r_frame [NUM_CH];
  logic signed [SAMPLE_W-1:0]  r_stage [NUM_CH];
  logic [NUM_CH-1:0]           r_stage_clip;
  logic signed [SAMPLE_W-1:0]  r_out   [NUM_CH];
  logic [NUM_CH-1:0]           r_clip;
  logic signed [SAMPLE_W-1:0]  w_in    [NUM_CH];

  logic                        w_accept;
  logic [GAIN_W-1:0]           w_eff;
  logic [GAIN_W-1:0]           w_diff;
  logic [GAIN_W-1:0]           w_next_gain;

  logic signed [SAMPLE_W-1:0]  w_sample;
  logic signed [c_prod_w-1:0]  w_sample_ext;
  logic signed [c_prod_w-1:0]  w_gain_ext;
  logic signed [c_prod_w-1:0]  w_prod;
  logic signed [c_prod_w-1:0]  w_rounded;
  logic signed [c_prod_w-1:0]  w_shifted;
  logic signed [SAMPLE_W-1:0]  w_result;
  logic                        w_clip;

  assign w_accept = (r_state == c_st_idle) && sample_ready;

  // Unpack the input bus and pack the output registers.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign w_in[k] = samples_in[k*SAMPLE_W +: SAMPLE_W];
    assign samples_out[k*SAMPLE_W +: SAMPLE_W] = r_out[k];
  end

  assign clip     = r_clip;
  assign cur_gain = r_cur_gain;
  assign overrun  = r_overrun;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // Next-state: one MUL cycle per channel, then a single DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (sample_ready) w_state_nxt = c_st_mul;
      c_st_mul:  if (r_idx == c_last_idx) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // FSM outputs: busy for the whole frame, out_valid only in DONE.
  always_comb begin
    busy      = (r_state != c_st_idle);
    out_valid = (r_state == c_st_done);
  end

  // Gain ramp toward the effective target, bounded to one step per frame.
  always_comb begin
    w_eff       = mute ? '0 : target_gain;
    w_diff      = '0;
    w_next_gain = r_cur_gain;
    if (r_cur_gain < w_eff) begin
      w_diff      = w_eff - r_cur_gain;
      w_next_gain = (w_diff > c_step) ? (r_cur_gain + c_step) : w_eff;
    end else if (r_cur_gain > w_eff) begin
      w_diff      = r_cur_gain - w_eff;
      w_next_gain = (w_diff > c_step) ? (r_cur_gain - c_step) : w_eff;
    end
  end

  // Shared multiplier: full-precision product, round-half-up, saturate.
  always_comb begin
    w_sample     = r_frame[r_idx];
    w_sample_ext = {{(GAIN_W+1){w_sample[SAMPLE_W-1]}}, w_sample};
    w_gain_ext   = {{(SAMPLE_W+1){1'b0}}, r_cur_gain};
    w_prod       = w_sample_ext * w_gain_ext;
    w_rounded    = w_prod + c_round;
    w_shifted    = w_rounded >>> FRAC_W;
    w_clip       = 1'b0;
    w_result     = w_shifted[SAMPLE_W-1:0];
    if (w_shifted > c_sat_max) begin
      w_result = {1'b0, {(SAMPLE_W-1){1'b1}}};
      w_clip   = 1'b1;
    end else if (w_shifted < c_sat_min) begin
      w_result = {1'b1, {(SAMPLE_W-1){1'b0}}};
      w_clip   = 1'b1;
    end
  end

  // Frame latch, ramp step, per-channel staging and simultaneous output update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx        <= '0;
      r_cur_gain   <= c_unity;
      r_overrun    <= 1'b0;
      r_clip       <= '0;
      r_stage_clip <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_frame[k] <= '0;
        r_stage[k] <= '0;
        r_out[k]   <= '0;
      end
    end else begin
      r_overrun <= sample_ready && (r_state != c_st_idle);
      if (w_accept) begin
        r_idx      <= '0;
        r_cur_gain <= w_next_gain;
        for (int k = 0; k < NUM_CH; k++) r_frame[k] <= w_in[k];
      end
      if (r_state == c_st_mul) begin
        r_idx                <= r_idx + c_idx_w'(1);
        r_stage[r_idx]       <= w_result;
        r_stage_clip[r_idx]  <= w_clip;
        if (r_idx == c_last_idx) begin
          for (int k = 0; k < NUM_CH; k++) begin
            r_out[k]  <= r_stage[k];
            r_clip[k] <= r_stage_clip[k];
          end
          // The last channel bypasses staging so all channels land together.
          r_out[NUM_CH-1]  <= w_result;
          r_clip[NUM_CH-1] <= w_clip;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gain_ramp_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_gain_ramp_multi
// Brief    : Directed self-checking bench for gain_ramp_multi (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gain_ramp_multi;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        sample_ready;
  logic [47:0] samples_in;
  logic [15:0] target_gain;
  logic        mute;
  logic [47:0] samples_out;
  logic        out_valid;
  logic [1:0]  clip;
  logic [15:0] cur_gain;
  logic        busy;
  logic        overrun;

  logic signed [23:0] out_l;
  logic signed [23:0] out_r;
  assign out_l = samples_out[23:0];
  assign out_r = samples_out[47:24];

  int n_pass  = 0;
  int n_total = 0;

  gain_ramp_multi #(
    .NUM_CH(2), .SAMPLE_W(24), .GAIN_W(16), .FRAC_W(12), .RAMP_STEP(256)
  ) dut (
    .CLK(CLK), .RESET(RESET), .sample_ready(sample_ready),
    .samples_in(samples_in), .target_gain(target_gain), .mute(mute),
    .samples_out(samples_out), .out_valid(out_valid), .clip(clip),
    .cur_gain(cur_gain), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Drive one frame, wait (bounded) for out_valid, return latency in cycles,
  // then step one more cycle so the DUT is back in IDLE.
  task automatic run_frame(input logic signed [23:0] l, input logic signed [23:0] r,
                           output int lat);
    samples_in   = {r, l};
    sample_ready = 1'b1;
    @(posedge CLK); #1;
    sample_ready = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; sample_ready = 1'b1; mute = 1'b0;
    target_gain = 16'd4096; samples_in = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_total++; if (samples_out !== 48'd0) $display("FAIL reset_samples_out got %0h want 0", samples_out); else n_pass++;
    n_total++; if (clip !== 2'b00) $display("FAIL reset_clip got %b want 00", clip); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (cur_gain !== 16'd4096) $display("FAIL reset_cur_gain got %0d want 4096", cur_gain); else n_pass++;
    sample_ready = 1'b0; RESET = 1'b0;
  endtask

  task automatic test_unity;
    int lat;
    target_gain = 16'd4096;
    run_frame(24'sd4096, -24'sd4096, lat);
    n_total++; if (lat != 3) $display("FAIL unity_latency got %0d want 3", lat); else n_pass++;
    n_total++; if (out_l !== 24'sd4096) $display("FAIL unity_L got %0d want 4096", out_l); else n_pass++;
    n_total++; if (out_r !== -24'sd4096) $display("FAIL unity_R got %0d want -4096", out_r); else n_pass++;
    n_total++; if (clip !== 2'b00) $display("FAIL unity_clip got %b want 00", clip); else n_pass++;
    n_total++; if (cur_gain !== 16'd4096) $display("FAIL unity_gain got %0d want 4096", cur_gain); else n_pass++;
  endtask

  task automatic test_busy_timing;
    logic exp_busy, exp_ov;
    samples_in = {24'sd5, 24'sd5};
    sample_ready = 1'b1;
    @(posedge CLK); #1;
    sample_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_busy = (c <= 3);
      exp_ov   = (c == 3);
      n_total++; if (busy !== exp_busy) $display("FAIL busy_t+%0d got %b want %b", c, busy, exp_busy); else n_pass++;
      n_total++; if (out_valid !== exp_ov) $display("FAIL out_valid_t+%0d got %b want %b", c, out_valid, exp_ov); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_ramp_up;
    int lat, g;
    target_gain = 16'd8192;
    for (int i = 1; i <= 17; i++) begin
      run_frame(24'sd4096, -24'sd7, lat);
      g = (i <= 16) ? 4096 + 256 * i : 8192;
      n_total++; if (cur_gain !== 16'(g)) $display("FAIL ramp_gain_f%0d got %0d want %0d", i, cur_gain, g); else n_pass++;
      n_total++; if (out_l !== 24'(g)) $display("FAIL ramp_L_f%0d got %0d want %0d", i, out_l, g); else n_pass++;
      if (i == 1) begin
        n_total++; if (out_r !== -24'sd7) $display("FAIL ramp_R_round got %0d want -7", out_r); else n_pass++;
        n_total++; if (lat != 3) $display("FAIL ramp_latency got %0d want 3", lat); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation;
    int lat;
    run_frame(24'sh600000, -24'sh600000, lat);
    n_total++; if (samples_out[23:0] !== 24'h7FFFFF) $display("FAIL sat_L got %0h want 7fffff", samples_out[23:0]); else n_pass++;
    n_total++; if (samples_out[47:24] !== 24'h800000) $display("FAIL sat_R got %0h want 800000", samples_out[47:24]); else n_pass++;
    n_total++; if (clip !== 2'b11) $display("FAIL sat_clip got %b want 11", clip); else n_pass++;
    run_frame(24'sh3FFFFF, -24'sh400000, lat);
    n_total++; if (samples_out[23:0] !== 24'h7FFFFE) $display("FAIL edge_L got %0h want 7ffffe", samples_out[23:0]); else n_pass++;
    n_total++; if (samples_out[47:24] !== 24'h800000) $display("FAIL edge_R got %0h want 800000", samples_out[47:24]); else n_pass++;
    n_total++; if (clip !== 2'b00) $display("FAIL edge_clip got %b want 00", clip); else n_pass++;
    run_frame(24'sd1, -24'sd1, lat);
    n_total++; if (out_l !== 24'sd2 || out_r !== -24'sd2) $display("FAIL small_LR got %0d,%0d want 2,-2", out_l, out_r); else n_pass++;
  endtask

  task automatic test_mute;
    int lat, g;
    RESET = 1'b1; @(posedge CLK); #1; RESET = 1'b0;
    target_gain = 16'd4096; mute = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      run_frame(24'sd4096, -24'sd4096, lat);
      g = (i <= 16) ? 4096 - 256 * i : 0;
      n_total++; if (cur_gain !== 16'(g)) $display("FAIL mute_gain_f%0d got %0d want %0d", i, cur_gain, g); else n_pass++;
      n_total++; if (out_l !== 24'(g)) $display("FAIL mute_L_f%0d got %0d want %0d", i, out_l, g); else n_pass++;
    end
    n_total++; if (out_r !== 24'sd0) $display("FAIL mute_R got %0d want 0", out_r); else n_pass++;
    mute = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      run_frame(24'sd4096, -24'sd4096, lat);
      g = 256 * i;
      n_total++; if (cur_gain !== 16'(g)) $display("FAIL unmute_gain_f%0d got %0d want %0d", i, cur_gain, g); else n_pass++;
    end
  endtask

  task automatic test_idle_hold;
    target_gain = 16'd8192;
    mute = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    n_total++; if (cur_gain !== 16'd4096) $display("FAIL idle_gain got %0d want 4096", cur_gain); else n_pass++;
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL idle_flags got %b%b want 00", busy, out_valid); else n_pass++;
    mute = 1'b0;
  endtask

  task automatic test_overrun;
    int nv;
    target_gain  = 16'd8192;
    samples_in   = {-24'sd4096, 24'sd4096};
    sample_ready = 1'b1;
    @(posedge CLK); #1;                         // t+1, second request while busy
    samples_in = {24'sd1000, 24'sd1000};
    n_total++; if (overrun !== 1'b0) $display("FAIL ovr_t+1 got %b want 0", overrun); else n_pass++;
    nv = (out_valid === 1'b1) ? 1 : 0;
    @(posedge CLK); #1;                         // t+2
    sample_ready = 1'b0;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_t+2 got %b want 1", overrun); else n_pass++;
    nv += (out_valid === 1'b1) ? 1 : 0;
    @(posedge CLK); #1;                         // t+3
    n_total++; if (out_valid !== 1'b1) $display("FAIL ovr_valid_t+3 got %b want 1", out_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL ovr_t+3 got %b want 0", overrun); else n_pass++;
    n_total++; if (out_l !== 24'sd4352) $display("FAIL ovr_L got %0d want 4352", out_l); else n_pass++;
    n_total++; if (cur_gain !== 16'd4352) $display("FAIL ovr_gain got %0d want 4352", cur_gain); else n_pass++;
    nv += (out_valid === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(posedge CLK); #1;
      nv += (out_valid === 1'b1) ? 1 : 0;
    end
    n_total++; if (nv != 1) $display("FAIL ovr_valid_count got %0d want 1", nv); else n_pass++;
    n_total++; if (cur_gain !== 16'd4352) $display("FAIL ovr_gain_after got %0d want 4352", cur_gain); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int nv, lat;
    target_gain  = 16'd8192;
    samples_in   = {24'sd4096, 24'sd4096};
    sample_ready = 1'b1;
    @(posedge CLK); #1;                         // t+1
    sample_ready = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    nv = 0;
    repeat (5) begin
      nv += (out_valid === 1'b1) ? 1 : 0;
      @(posedge CLK); #1;
    end
    n_total++; if (nv != 0) $display("FAIL rstmid_valid_count got %0d want 0", nv); else n_pass++;
    n_total++; if (samples_out !== 48'd0) $display("FAIL rstmid_out got %0h want 0", samples_out); else n_pass++;
    n_total++; if (cur_gain !== 16'd4096) $display("FAIL rstmid_gain got %0d want 4096", cur_gain); else n_pass++;
    target_gain = 16'd4096;
    run_frame(24'sd100, -24'sd100, lat);
    n_total++; if (lat != 3) $display("FAIL rstmid_next_latency got %0d want 3", lat); else n_pass++;
    n_total++; if (out_l !== 24'sd100 || out_r !== -24'sd100) $display("FAIL rstmid_next_LR got %0d,%0d want 100,-100", out_l, out_r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_busy_timing();
    test_ramp_up();
    test_saturation();
    test_mute();
    test_idle_hold();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gain_ramp_multi.md
GAIN_RAMP_MULTI -- requirements
Module: gain_ramp_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of audio channels (1..16).
REQ-002 SHALL have parameter SAMPLE_W, default 24, signed two's-complement sample width.
REQ-003 SHALL have parameter GAIN_W, default 16, unsigned fixed-point gain width.
REQ-004 SHALL have parameter FRAC_W, default 12, fractional bits of gain (unity = 2^FRAC_W).
REQ-005 SHALL have parameter RAMP_STEP, default 256, maximum gain change per frame (LSBs).
REQ-006 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have port sample_ready  input  1  one-cycle pulse, new frame available on samples_in.
REQ-009 SHALL have port samples_in  input  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-010 SHALL have port target_gain  input  GAIN_W  requested gain, unsigned Q(GAIN_W-FRAC_W).FRAC_W.
REQ-011 SHALL have port mute  input  1  level; forces effective target to 0.
REQ-012 SHALL have port samples_out  output  NUM_CH*SAMPLE_W  scaled frame, same packing as samples_in.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse when samples_out updates.
REQ-014 SHALL have port clip  output  NUM_CH  per-channel saturation flag for the last output frame.
REQ-015 SHALL have port cur_gain  output  GAIN_W  gain applied to the most recent frame.
REQ-016 SHALL have port busy  output  1  high while a frame is in process.
REQ-017 SHALL have port overrun  output  1  one-cycle pulse when sample_ready arrives while busy.

Function
REQ-018 SHALL implement FSM states IDLE, MUL, DONE; IDLE->MUL on sample_ready, MUL->DONE after channel NUM_CH-1, DONE->IDLE unconditionally.
REQ-019 SHALL, on IDLE accept, latch samples_in and update cur_gain by one ramp step in the same edge; latched frame uses the updated gain.
REQ-020 SHALL compute the ramp as: eff = mute ? 0 : target_gain; if cur_gain < eff then cur_gain = min(cur_gain+RAMP_STEP, eff); if greater then max(cur_gain-RAMP_STEP, eff); else unchanged.
REQ-021 SHALL use one shared multiplier, processing channel index 0..NUM_CH-1 one per cycle in MUL.
REQ-022 SHALL compute each result as (sample * gain + 2^(FRAC_W-1)) arithmetically shifted right FRAC_W, full-precision product (SAMPLE_W+GAIN_W+1 bits, gain zero-extended).
REQ-023 SHALL saturate results to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and set that channel's clip bit when saturating.
REQ-024 SHALL update all of samples_out and clip simultaneously in DONE and pulse out_valid that cycle; outputs hold otherwise.
REQ-025 SHALL give latency: sample_ready at cycle t -> out_valid at cycle t+NUM_CH+1; busy high cycles t+1..t+NUM_CH+1.
REQ-026 SHALL ignore sample_ready while busy (no latch, no ramp step) and pulse overrun in the cycle after it.
REQ-027 SHALL change no gain while idle; target_gain and mute are sampled only on accept.

Reset
REQ-028 SHALL, on RESET, drive samples_out=0, clip=0, out_valid=0, overrun=0, busy=0, cur_gain=2^FRAC_W, state=IDLE.
REQ-029 SHALL abandon any in-progress frame on RESET with no out_valid for it; RESET dominates simultaneous sample_ready.

Verification (NUM_CH=2, SAMPLE_W=24, GAIN_W=16, FRAC_W=12, RAMP_STEP=256)
REQ-030 SHALL cover unity: after reset, target=4096, in L=4096, R=-4096, sample_ready at t -> out_valid at t+3, out L=4096, R=-4096, clip=0.
REQ-031 SHALL cover ramp-up: target=8192 from 4096, frames of L=4096 -> cur_gain 4352, 4608, ... reaching 8192 on frame 16; frame 1 out L=4352.
REQ-032 SHALL cover saturation: gain settled at 8192, L=0x600000, R=-0x600000 -> out L=0x7FFFFF, R=0x800000, clip=2'b11.
REQ-033 SHALL cover mute: gain 4096, mute=1 -> cur_gain falls 256 per frame, 0 on frame 16, outputs 0 thereafter; mute=0 ramps back to target.
REQ-034 SHALL cover overrun: sample_ready at t and t+1 -> single out_valid at t+3, overrun pulse at t+2, cur_gain stepped once.
REQ-035 SHALL cover reset mid-frame: RESET at t+1 after accept -> no out_valid, samples_out=0, cur_gain=4096, next frame processed normally.
